count_ones_reg: RTL and testbench

- Registered population-count block: counts the '1' bits in a WIDTH-bit input word and presents the count plus derived flags one clock later.
- Used wherever a bit-vector occupancy or weight is needed, e.g. request-vector counting or parity and weight checks.
- Single clock domain; synchronous active-high reset.

---
 rtl/count_ones_reg_if.sv | 24 ++
 rtl/count_ones_reg.sv | 65 ++++++
 tb/tb_count_ones_reg.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/count_ones_reg_if.sv
// Request/response bundle for the registered population counter.
// The master drives a word to be counted; the slave returns the count and flags.
interface count_ones_reg_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             in_valid;
    logic [WIDTH-1:0] binary_in;
    logic [CNT_W-1:0] ones_count;
    logic             out_valid;
    logic             is_zero;
    logic             is_full;
    logic             parity;

    modport master (
        output in_valid, binary_in,
        input  ones_count, out_valid, is_zero, is_full, parity
    );

    modport slave (
        input  in_valid, binary_in,
        output ones_count, out_valid, is_zero, is_full, parity
    );
endinterface

// File: rtl/count_ones_reg.sv
// Registered population count: counts '1' bits of an accepted word and
// presents count, zero/full/parity flags one clock later. All outputs are flops.
module count_ones_reg #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    count_ones_reg_if.slave    bus
);
    generate
        if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
            $error("count_ones_reg: WIDTH must be in 1..64");
        end
        if (CNT_W < $clog2(WIDTH + 1)) begin : g_bad_cnt_w
            $error("count_ones_reg: CNT_W too small to hold WIDTH");
        end
    endgenerate

    logic [CNT_W-1:0] w_sum;
    logic             w_zero;
    logic             w_full;
    logic             w_par;

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < WIDTH; i++)
            w_sum = w_sum + CNT_W'(bus.binary_in[i]);
    end

    assign w_zero = ~|bus.binary_in;
    assign w_full = &bus.binary_in;
    assign w_par  = ^bus.binary_in;

    logic [CNT_W-1:0] r_ones_count;
    logic             r_out_valid;
    logic             r_is_zero;
    logic             r_is_full;
    logic             r_parity;

    // Data flops only load on accept, so idle-cycle garbage on binary_in never reaches outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ones_count <= '0;
            r_out_valid  <= 1'b0;
            r_is_zero    <= 1'b1;
            r_is_full    <= 1'b0;
            r_parity     <= 1'b0;
        end else if (bus.in_valid) begin
            r_ones_count <= w_sum;
            r_out_valid  <= 1'b1;
            r_is_zero    <= w_zero;
            r_is_full    <= w_full;
            r_parity     <= w_par;
        end else begin
            r_out_valid  <= 1'b0;
        end
    end

    assign bus.ones_count = r_ones_count;
    assign bus.out_valid  = r_out_valid;
    assign bus.is_zero    = r_is_zero;
    assign bus.is_full    = r_is_full;
    assign bus.parity     = r_parity;
endmodule

// File: tb/tb_count_ones_reg.sv
// Self-checking bench for count_ones_reg: directed, random and streaming stimulus
// against a behavioural popcount model; extra instances cover WIDTH=1 and WIDTH=16.
module tb_count_ones_reg;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    count_ones_reg_if #(.WIDTH(8),  .CNT_W(4)) u_if8  ();
    count_ones_reg_if #(.WIDTH(1),  .CNT_W(1)) u_if1  ();
    count_ones_reg_if #(.WIDTH(16), .CNT_W(5)) u_if16 ();

    count_ones_reg #(.WIDTH(8),  .CNT_W(4)) u_dut8  (.clk(clk), .rst(rst), .bus(u_if8));
    count_ones_reg #(.WIDTH(1),  .CNT_W(1)) u_dut1  (.clk(clk), .rst(rst), .bus(u_if1));
    count_ones_reg #(.WIDTH(16), .CNT_W(5)) u_dut16 (.clk(clk), .rst(rst), .bus(u_if16));

    int n_pass  = 0;
    int n_total = 0;

    // Expected 8-bit outputs: {count[3:0], out_valid, is_zero, is_full, parity}
    logic [3:0] m_cnt;
    logic       m_vld, m_zero, m_full, m_par;
    logic [7:0] exp8, act8;

    // Drive one cycle on the WIDTH=8 instance and advance the model.
    task automatic drive8(input logic r, input logic v, input logic [7:0] w);
        int c;
        rst = r;
        u_if8.in_valid  = v;
        u_if8.binary_in = w;
        c = $countones(w);
        if (r) begin
            m_cnt = 0; m_vld = 0; m_zero = 1; m_full = 0; m_par = 0;
        end else if (v) begin
            m_cnt = 4'(c); m_vld = 1; m_zero = (c == 0); m_full = (c == 8); m_par = c[0];
        end else begin
            m_vld = 0;
        end
        exp8 = {m_cnt, m_vld, m_zero, m_full, m_par};
        @(posedge clk);
        #1;
        act8 = {u_if8.ones_count, u_if8.out_valid, u_if8.is_zero, u_if8.is_full, u_if8.parity};
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive8(1'b1, 1'b1, 8'hFF);
            n_total++;
            if (act8 !== 8'b0000_0100)
                $display("FAIL reset[%0d] got {cnt,v,z,f,p}=%b expected %b", i, act8, 8'b0000_0100);
            else n_pass++;
        end
    endtask

    task automatic test_directed();
        logic [7:0] vec [9] = '{8'h00, 8'hFF, 8'hAA, 8'hCC, 8'hE6, 8'h81, 8'h26, 8'h0F, 8'h55};
        logic [3:0] cnt [9] = '{4'd0, 4'd8, 4'd4, 4'd4, 4'd5, 4'd2, 4'd3, 4'd4, 4'd4};
        for (int i = 0; i < 9; i++) begin
            drive8(1'b0, 1'b1, vec[i]);
            n_total++;
            if (act8 !== exp8 || act8[7:4] !== cnt[i])
                $display("FAIL directed 0x%02h got %b expected %b (count %0d)", vec[i], act8, exp8, cnt[i]);
            else n_pass++;
        end
    endtask

    task automatic test_hold();
        drive8(1'b0, 1'b1, 8'hE6);
        for (int i = 0; i < 5; i++) begin
            drive8(1'b0, 1'b0, 8'($urandom));
            if (i[0]) u_if8.binary_in = 'x;
            n_total++;
            if (act8 !== 8'b0101_0001 || act8 !== exp8)
                $display("FAIL hold[%0d] got %b expected %b", i, act8, 8'b0101_0001);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            drive8(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
            n_total++;
            if (act8 !== exp8)
                $display("FAIL random[%0d] got %b expected %b", i, act8, exp8);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        for (int i = 0; i < 256; i++) begin
            drive8(1'b0, 1'b1, 8'(i));
            n_total++;
            if (act8 !== exp8 || act8[3] !== 1'b1) begin
                bad++;
                if (bad < 5) $display("FAIL stream word 0x%02h got %b expected %b", i, act8, exp8);
            end else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        drive8(1'b0, 1'b1, 8'hFF);
        drive8(1'b0, 1'b1, 8'hFF);
        drive8(1'b1, 1'b1, 8'hFF);
        n_total++;
        if (act8 !== 8'b0000_0100)
            $display("FAIL reset_mid got %b expected %b", act8, 8'b0000_0100);
        else n_pass++;
        drive8(1'b0, 1'b1, 8'h26);
        n_total++;
        if (act8 !== 8'b0011_1001)
            $display("FAIL reset_mid_resume got %b expected %b", act8, 8'b0011_1001);
        else n_pass++;
        drive8(1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_params();
        logic [15:0] w;
        u_if1.in_valid = 1;  u_if1.binary_in = 1'b1;
        u_if16.in_valid = 1; u_if16.binary_in = 16'hFFFF;
        @(posedge clk); #1;
        n_total++;
        if ({u_if1.ones_count, u_if1.is_full, u_if1.is_zero} !== 3'b110)
            $display("FAIL w1_ones got {cnt,f,z}=%b expected 110", {u_if1.ones_count, u_if1.is_full, u_if1.is_zero});
        else n_pass++;
        n_total++;
        if ({u_if16.ones_count, u_if16.is_full, u_if16.out_valid} !== {5'd16, 2'b11})
            $display("FAIL w16_full got cnt=%0d f=%b v=%b expected 16 1 1", u_if16.ones_count, u_if16.is_full, u_if16.out_valid);
        else n_pass++;
        u_if1.binary_in = 1'b0;
        @(posedge clk); #1;
        n_total++;
        if ({u_if1.ones_count, u_if1.is_full, u_if1.is_zero} !== 3'b001)
            $display("FAIL w1_zero got {cnt,f,z}=%b expected 001", {u_if1.ones_count, u_if1.is_full, u_if1.is_zero});
        else n_pass++;
        for (int i = 0; i < 20; i++) begin
            w = 16'($urandom);
            u_if16.binary_in = w;
            @(posedge clk); #1;
            n_total++;
            if (u_if16.ones_count !== 5'($countones(w)) || u_if16.parity !== ($countones(w) % 2 == 1))
                $display("FAIL w16_rand 0x%04h got cnt=%0d p=%b expected cnt=%0d", w, u_if16.ones_count, u_if16.parity, $countones(w));
            else n_pass++;
        end
        u_if1.in_valid = 0;
        u_if16.in_valid = 0;
    endtask

    initial begin
        rst = 1'b1;
        u_if8.in_valid = 0;  u_if8.binary_in = '0;
        u_if1.in_valid = 0;  u_if1.binary_in = '0;
        u_if16.in_valid = 0; u_if16.binary_in = '0;
        test_reset();
        test_directed();
        test_hold();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_params();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
